// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the instruction/data memory arbiter.
// Block geometry is fixed: eight 16-bit words per cache block.
package mem_arb_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = 3;
    localparam int ISSUE_CNT_W = WORD_IDX_W + 1;

    localparam logic [WORD_IDX_W-1:0]  LAST_WORD   = WORD_IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ISSUE_CNT_W-1:0] ISSUE_LIMIT = ISSUE_CNT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Issue and receive word counters for one block fill.
// The issue counter saturates at BLOCK_WORDS; the receive counter wraps on the last word.
module fill_counter
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  issue_inc,
    input  logic                  recv_inc,
    output logic [WORD_IDX_W-1:0] issue_idx,
    output logic [WORD_IDX_W-1:0] recv_cnt,
    output logic                  issue_done
);

    logic [ISSUE_CNT_W-1:0] issue_cnt;

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (issue_inc && !issue_done) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (recv_inc) begin
                recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

    assign issue_done = (issue_cnt == ISSUE_LIMIT);
    assign issue_idx  = issue_cnt[WORD_IDX_W-1:0];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and
// D-side write-throughs; one transaction in flight, priority d_wr > d_miss > i_miss.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss,
    input  logic [15:0]           i_addr,
    input  logic                  d_miss,
    input  logic [15:0]           d_addr,
    input  logic                  d_wr,
    input  logic [15:0]           d_wr_addr,
    input  logic [15:0]           d_wr_data,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [15:0]           mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rvalid,
    output logic [15:0]           fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_fill_we,
    output logic                  d_fill_we,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  d_wr_ack,
    output logic                  busy
);

    state_t                state;
    owner_t                owner;
    logic [11:0]           base;
    logic [WORD_IDX_W-1:0] issue_idx;
    logic [WORD_IDX_W-1:0] recv_cnt;
    logic                  issue_done;
    logic                  fill_grant;
    logic                  issuing;
    logic                  fill_rx;
    logic                  last_word;
    logic                  unused_addr_bits;

    // Block-aligned requests: the low nibble of a miss address never reaches memory.
    assign unused_addr_bits = ^{i_addr[3:0], d_addr[3:0]};

    assign fill_grant = (state == IDLE) && !d_wr && (d_miss || i_miss);
    assign issuing    = (state == FILL) && !issue_done;
    assign fill_rx    = (state == FILL) && mem_rvalid;
    assign last_word  = fill_rx && (recv_cnt == LAST_WORD);

    fill_counter u_fill_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (fill_grant),
        .issue_inc  (issuing),
        .recv_inc   (fill_rx),
        .issue_idx  (issue_idx),
        .recv_cnt   (recv_cnt),
        .issue_done (issue_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_I;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wr) begin
                        state <= WRITE;
                    end else if (d_miss) begin
                        state <= FILL;
                        owner <= OWN_D;
                        base  <= d_addr[15:4];
                    end else if (i_miss) begin
                        state <= FILL;
                        owner <= OWN_I;
                        base  <= i_addr[15:4];
                    end
                end
                WRITE:   state <= IDLE;
                FILL:    if (last_word) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Returned words are forwarded in the cycle they arrive, so the receive side is combinational.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_data = '0;
        fill_word = '0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        d_wr_ack  = 1'b0;
        busy      = (state != IDLE);

        if (state == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
        end

        if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = {base, issue_idx, 1'b0};
        end

        if (fill_rx) begin
            fill_data = mem_rdata;
            fill_word = recv_cnt;
            i_fill_we = (owner == OWN_I);
            d_fill_we = (owner == OWN_D);
            i_done    = last_word && (owner == OWN_I);
            d_done    = last_word && (owner == OWN_D);
        end
    end

endmodule
